inta_sequencer: RTL and testbench
=================================

INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have parameter RESET_BASE, default 5'b00000, meaning: vector base T7..T3 used until icw2_base is first loaded.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port irr_req  input  8  pending unmasked requests from the request/mask stage; bit n = IRn.
REQ-005 SHALL have port icw2_base  input  5  vector base T7..T3.
REQ-006 SHALL have port icw2_load  input  1  one-cycle strobe that latches icw2_base.
REQ-007 SHALL have port inta_n  input  1  CPU acknowledge, active-low, asynchronous to clk.
REQ-008 SHALL have port eoi_valid  input  1  one-cycle EOI command strobe.
REQ-009 SHALL have port eoi_specific  input  1  1 = specific EOI, 0 = non-specific EOI.
REQ-010 SHALL have port eoi_level  input  3  target IR level for a specific EOI.
REQ-011 SHALL have port int_out  output  1  interrupt request to the CPU, registered.
REQ-012 SHALL have port isr  output  8  in-service register.
REQ-013 SHALL have port irr_clear  output  8  one-hot, one-cycle pulse that clears the acknowledged request upstream.
REQ-014 SHALL have port data_out  output  8  vector byte.
REQ-015 SHALL have port data_oe  output  1  data bus drive enable.

Function
REQ-016 SHALL use fixed priority, IR0 highest and IR7 lowest.
REQ-017 SHALL define "qualified" as: the highest set bit-priority of irr_req is strictly higher than the highest-priority set isr bit, or isr is 0.
REQ-018 SHALL synchronize inta_n through 2 flops and act only on edges of the synchronized signal.
REQ-019 SHALL implement FSM states IDLE, PEND, ACK1, WAIT2 and ACK2.
REQ-020 SHALL make these FSM transitions:
- IDLE -> PEND when qualified.
- PEND -> ACK1 on synced inta falling edge.
- ACK1 -> WAIT2 on rising edge.
- WAIT2 -> ACK2 on falling edge.
- ACK2 -> IDLE on rising edge.
REQ-021 SHALL drive int_out = 1 in PEND only; int_out SHALL rise the cycle after the request is qualified.
REQ-022 SHALL return PEND -> IDLE, with int_out deasserted, if the request stops being qualified before the first INTA.
REQ-023 SHALL perform these actions on ACK1 entry, in one cycle:
- Freeze the highest qualified level L.
- Set isr[L].
- Pulse irr_clear = 1<<L.
REQ-024 SHALL treat it as spurious if no request is qualified at ACK1 entry: L = 7, isr unchanged, irr_clear = 0.
REQ-025 SHALL drive data_out = {base, L} and data_oe = 1 throughout ACK2 only; otherwise data_oe = 0 and data_out = 8'h00.
REQ-026 SHALL clear the highest-priority set isr bit on a non-specific EOI; no-op if isr = 0.
REQ-027 SHALL clear isr[eoi_level] on a specific EOI; no-op if that bit is already 0.
REQ-028 SHALL let the ISR set win over the clear if an EOI clear and an ACK1 set target the same bit in the same cycle; otherwise both SHALL apply.
REQ-029 SHALL ignore additional inta_n edges while in IDLE.
REQ-030 SHALL accept EOI in any state.
REQ-031 SHALL re-evaluate qualification only in IDLE and PEND.

Reset
REQ-032 SHALL, on rst_n low, immediately set state = IDLE, int_out = 0, isr = 8'h00, irr_clear = 8'h00, data_out = 8'h00, data_oe = 0, base = RESET_BASE, and clear the synchronizer flops to 1.
REQ-033 SHALL, if reset occurs mid-sequence (any state), leave no ISR bit set after release and SHALL require a fresh qualification to re-raise int_out.

Configuration
REQ-034 SHALL, with AUTO_EOI_EN defined, clear isr[L] on the ACK2 -> IDLE transition; EOI commands remain functional.
REQ-035 SHALL, without AUTO_EOI_EN, clear isr bits only via EOI.

Verification
REQ-036 SHALL cover basic acknowledge: base = 5'b01000, irr_req = 8'h08 -> int_out = 1 one cycle later; two INTA pulses -> irr_clear = 8'h08 for one cycle, isr = 8'h08, data_out = 8'h43 with data_oe = 1 during the second pulse only.
REQ-037 SHALL cover nesting: isr = 8'h08, irr_req = 8'h10 -> int_out stays 0; irr_req = 8'h02 -> int_out = 1, after acknowledge isr = 8'h0A and vector = 8'h41.
REQ-038 SHALL cover EOI: isr = 8'h0A, non-specific EOI -> isr = 8'h08; specific EOI level 3 -> isr = 8'h00; specific EOI level 5 -> no change.
REQ-039 SHALL cover spurious: int_out = 1, irr_req dropped to 0 after the first INTA begins -> data_out = 8'h47, isr unchanged, irr_clear = 8'h00.
REQ-040 SHALL cover reset mid-ACK2: rst_n low -> data_oe = 0, isr = 8'h00 immediately; after release with irr_req = 8'h01 held -> new int_out = 1.
REQ-041 SHALL cover auto-EOI: with AUTO_EOI_EN, acknowledge IR2 -> isr = 8'h04 during ACK2, 8'h00 the cycle after the second INTA rises.

Source files
------------

// File: rtl/inta_sequencer.sv
// inta_sequencer: fixed-priority INTA handshake sequencer with ISR tracking and EOI handling.
// Optional build macro AUTO_EOI_EN: clears the in-service bit automatically at the end of the second INTA.
`default_nettype none

module inta_sequencer #(
   parameter logic [4:0] RESET_BASE = 5'b00000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] irr_req,
   input  logic [4:0] icw2_base,
   input  logic       icw2_load,
   input  logic       inta_n,
   input  logic       eoi_valid,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
   output logic       int_out,
   output logic [7:0] isr,
   output logic [7:0] irr_clear,
   output logic [7:0] data_out,
   output logic       data_oe
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] PEND  = 3'd1;
   localparam logic [2:0] ACK1  = 3'd2;
   localparam logic [2:0] WAIT2 = 3'd3;
   localparam logic [2:0] ACK2  = 3'd4;

   // Index of the highest-priority (lowest-numbered) set bit.
   function automatic logic [2:0] pri_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd7;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   logic [2:0] state;
   logic [2:0] state_nx;
   logic       sync1;
   logic       sync2;
   logic       sync3;
   logic [4:0] base;
   logic [2:0] level;
   logic       spurious;

   logic       inta_fall;
   logic       inta_rise;
   logic [2:0] irr_idx;
   logic [2:0] isr_idx;
   logic       qualified;
   logic       take_ack;
   logic [7:0] set_mask;
   logic [7:0] eoi_mask;
   logic [7:0] auto_mask;
   logic [7:0] isr_nx;

   assign inta_fall = sync3 & ~sync2;
   assign inta_rise = ~sync3 & sync2;
   assign irr_idx   = pri_idx(irr_req);
   assign isr_idx   = pri_idx(isr);
   assign qualified = (irr_req != 8'h00) && ((isr == 8'h00) || (irr_idx < isr_idx));
   assign take_ack  = (state == PEND) && inta_fall;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (qualified) state_nx = PEND;
         // Once the first synchroniser stage has seen INTA low the cycle is
         // committed; a request that vanishes after that becomes spurious.
         PEND: begin
            if (inta_fall)                  state_nx = ACK1;
            else if (!qualified && sync1)   state_nx = IDLE;
         end
         ACK1:    if (inta_rise) state_nx = WAIT2;
         WAIT2:   if (inta_fall) state_nx = ACK2;
         ACK2:    if (inta_rise) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      set_mask  = 8'h00;
      eoi_mask  = 8'h00;
      auto_mask = 8'h00;
      if (take_ack && qualified) set_mask = 8'h01 << irr_idx;
      if (eoi_valid) begin
         if (eoi_specific)        eoi_mask = 8'h01 << eoi_level;
         else if (isr != 8'h00)   eoi_mask = 8'h01 << isr_idx;
      end
`ifdef AUTO_EOI_EN
      if ((state == ACK2) && inta_rise && !spurious) auto_mask = 8'h01 << level;
`else
      auto_mask = 8'h00;
`endif
      // Set is OR-ed last so an acknowledge wins over a same-bit clear.
      isr_nx = (isr & ~(eoi_mask | auto_mask)) | set_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync3     <= 1'b1;
         base      <= RESET_BASE;
         level     <= 3'd7;
         spurious  <= 1'b0;
         isr       <= 8'h00;
         int_out   <= 1'b0;
         irr_clear <= 8'h00;
         data_out  <= 8'h00;
         data_oe   <= 1'b0;
      end else begin
         state     <= state_nx;
         sync1     <= inta_n;
         sync2     <= sync1;
         sync3     <= sync2;
         if (icw2_load) base <= icw2_base;
         if (take_ack) begin
            level    <= qualified ? irr_idx : 3'd7;
            spurious <= !qualified;
         end
         isr       <= isr_nx;
         int_out   <= (state_nx == PEND);
         irr_clear <= set_mask;
         data_oe   <= (state_nx == ACK2);
         data_out  <= (state_nx == ACK2) ? {base, level} : 8'h00;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: table-driven acknowledge vectors plus hand-written corner sequences,
// with a vector scoreboard checked whenever data_oe rises.
`default_nettype none

module tb_inta_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irr_req;
   logic [4:0] icw2_base;
   logic       icw2_load;
   logic       inta_n;
   logic       eoi_valid;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       int_out;
   logic [7:0] isr;
   logic [7:0] irr_clear;
   logic [7:0] data_out;
   logic       data_oe;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   logic       oe_q = 1'b0;

   typedef struct {
      bit         load;
      logic [4:0] base;
      logic [7:0] irr;
      logic [7:0] exp_vec;
      logic [7:0] exp_clr;
      logic [7:0] exp_isr;
   } vec_t;

   vec_t tbl[4];

   inta_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .irr_req      (irr_req),
      .icw2_base    (icw2_base),
      .icw2_load    (icw2_load),
      .inta_n       (inta_n),
      .eoi_valid    (eoi_valid),
      .eoi_specific (eoi_specific),
      .eoi_level    (eoi_level),
      .int_out      (int_out),
      .isr          (isr),
      .irr_clear    (irr_clear),
      .data_out     (data_out),
      .data_oe      (data_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every vector presented on the bus must match the next expected one.
   always @(negedge clk) begin
      oe_q <= data_oe;
      if (data_oe && !oe_q) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL vector_unexpected: got %0h expected none", data_out);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               bad++;
               $display("FAIL vector: got %0h expected %0h", data_out, e);
            end
         end
      end
   end

   task automatic eoi(input bit spec, input logic [2:0] lvl);
      eoi_valid    = 1'b1;
      eoi_specific = spec;
      eoi_level    = lvl;
      @(negedge clk);
      eoi_valid    = 1'b0;
   endtask

   task automatic clear_isr();
      for (int l = 0; l < 8; l++) eoi(1'b1, 3'(l));
   endtask

   task automatic load_base(input logic [4:0] b);
      icw2_base = b;
      icw2_load = 1'b1;
      @(negedge clk);
      icw2_load = 1'b0;
   endtask

   // Two INTA pulses, each 4 cycles low with 4 cycles high between them.
   task automatic ack_seq(input bit drop, output logic [7:0] clr_seen, output int clr_n,
                          output int oe_n, output logic [7:0] isr_oe);
      clr_seen = 8'h00;
      clr_n    = 0;
      oe_n     = 0;
      isr_oe   = 8'h00;
      inta_n   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (irr_clear != 8'h00) begin
            clr_n++;
            clr_seen |= irr_clear;
         end
         if (data_oe) begin
            oe_n++;
            isr_oe = isr;
         end
         if (drop && i == 0) irr_req = 8'h00;
         inta_n = !((i < 3) || (i >= 7 && i < 11));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] clr_seen;
      logic [7:0] isr_oe;
      int         clr_n;
      int         oe_n;

      tbl[0] = '{1'b0, 5'b00000, 8'h80, 8'h07, 8'h80, 8'h80};
      tbl[1] = '{1'b1, 5'b01000, 8'h08, 8'h43, 8'h08, 8'h08};
      tbl[2] = '{1'b1, 5'b10101, 8'hF0, 8'hAC, 8'h10, 8'h10};
      tbl[3] = '{1'b1, 5'b11111, 8'h81, 8'hF8, 8'h01, 8'h01};

      rst_n        = 1'b0;
      irr_req      = 8'h00;
      icw2_base    = 5'b00000;
      icw2_load    = 1'b0;
      inta_n       = 1'b1;
      eoi_valid    = 1'b0;
      eoi_specific = 1'b0;
      eoi_level    = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_int_out", int_out, 0);
      check("rst_isr", isr, 8'h00);
      check("rst_irr_clear", irr_clear, 8'h00);
      check("rst_data_out", data_out, 8'h00);
      check("rst_data_oe", data_oe, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         clear_isr();
         if (tbl[i].load) load_base(tbl[i].base);
         check($sformatf("row%0d_int_before", i), int_out, 0);
         irr_req = tbl[i].irr;
         @(negedge clk);
         check($sformatf("row%0d_int_after", i), int_out, 1);
         exp_q.push_back(tbl[i].exp_vec);
         ack_seq(1'b0, clr_seen, clr_n, oe_n, isr_oe);
         irr_req = 8'h00;
         check($sformatf("row%0d_irr_clear", i), clr_seen, tbl[i].exp_clr);
         check($sformatf("row%0d_clr_cycles", i), clr_n, 1);
         check($sformatf("row%0d_oe_cycles", i), oe_n, 4);
         check($sformatf("row%0d_isr", i), isr, tbl[i].exp_isr);
         check($sformatf("row%0d_int_done", i), int_out, 0);
      end

      // Nesting: lower priority blocked, higher priority accepted.
      clear_isr();
      load_base(5'b01000);
      irr_req = 8'h08;
      @(negedge clk);
      exp_q.push_back(8'h43);
      ack_seq(1'b0, clr_seen, clr_n, oe_n, isr_oe);
      irr_req = 8'h00;
      check("nest_isr_first", isr, 8'h08);
      irr_req = 8'h10;
      repeat (3) @(negedge clk);
      check("nest_lower_blocked", int_out, 0);
      irr_req = 8'h02;
      @(negedge clk);
      check("nest_higher_int", int_out, 1);
      exp_q.push_back(8'h41);
      ack_seq(1'b0, clr_seen, clr_n, oe_n, isr_oe);
      irr_req = 8'h00;
      check("nest_clr", clr_seen, 8'h02);
      check("nest_isr", isr, 8'h0A);

      // Request withdrawn before any INTA.
      irr_req = 8'h01;
      @(negedge clk);
      check("withdraw_int_up", int_out, 1);
      irr_req = 8'h00;
      @(negedge clk);
      check("withdraw_int_down", int_out, 0);

      // EOI handling.
      eoi(1'b0, 3'd0);
      check("eoi_nonspecific", isr, 8'h08);
      eoi(1'b1, 3'd5);
      check("eoi_specific_noop", isr, 8'h08);
      eoi(1'b1, 3'd3);
      check("eoi_specific_l3", isr, 8'h00);
      eoi(1'b0, 3'd0);
      check("eoi_nonspecific_empty", isr, 8'h00);

      // Spurious: request dropped once the first INTA has begun.
      irr_req = 8'h08;
      @(negedge clk);
      exp_q.push_back(8'h43);
      ack_seq(1'b0, clr_seen, clr_n, oe_n, isr_oe);
      irr_req = 8'h02;
      @(negedge clk);
      check("spur_int", int_out, 1);
      exp_q.push_back(8'h47);
      ack_seq(1'b1, clr_seen, clr_n, oe_n, isr_oe);
      check("spur_irr_clear", clr_seen, 8'h00);
      check("spur_isr", isr, 8'h08);
      check("spur_oe_cycles", oe_n, 4);
      eoi(1'b1, 3'd3);

      // Auto-EOI behaviour (or its absence in the default build).
      irr_req = 8'h04;
      @(negedge clk);
      exp_q.push_back(8'h42);
      ack_seq(1'b0, clr_seen, clr_n, oe_n, isr_oe);
      irr_req = 8'h00;
      check("auto_isr_in_ack2", isr_oe, 8'h04);
`ifdef AUTO_EOI_EN
      check("auto_isr_after", isr, 8'h00);
`else
      check("manual_isr_after", isr, 8'h04);
`endif
      eoi(1'b1, 3'd2);
      check("auto_cleanup", isr, 8'h00);

      // Reset in the middle of the second INTA pulse.
      irr_req = 8'h01;
      @(negedge clk);
      exp_q.push_back(8'h40);
      inta_n = 1'b0;
      repeat (4) @(negedge clk);
      inta_n = 1'b1;
      repeat (4) @(negedge clk);
      inta_n = 1'b0;
      repeat (6) @(negedge clk);
      check("rst_mid_oe_before", data_oe, 1);
      check("rst_mid_isr_before", isr, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_oe", data_oe, 0);
      check("rst_mid_isr", isr, 8'h00);
      check("rst_mid_data", data_out, 8'h00);
      check("rst_mid_int", int_out, 0);
      inta_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_int", int_out, 1);
      exp_q.push_back(8'h00 | 8'h00);
      // Base reverts to RESET_BASE after reset.
      exp_q.pop_back();
      exp_q.push_back(8'h00);
      ack_seq(1'b0, clr_seen, clr_n, oe_n, isr_oe);
      irr_req = 8'h00;
      check("rst_release_isr", isr, 8'h01);
      check("rst_release_clr", clr_seen, 8'h01);

      repeat (2) @(negedge clk);
      check("scoreboard_drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
